// File: rtl/apb_pkg.sv
// Shared types for the APB master controller: FSM states and response codes.
package apb_pkg;

  localparam int STATUS_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  typedef enum logic [STATUS_W-1:0] {
    OKAY    = 2'd0,
    SLVERR  = 2'd1,
    DECERR  = 2'd2,
    TIMEOUT = 2'd3
  } apb_status_t;

endpackage

// File: rtl/apb_slave_mux.sv
// Return-path multiplexer: picks the selected slave's PREADY/PSLVERR/PRDATA
// using the slave index registered at request accept.
module apb_slave_mux #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_W     = 32,
  parameter int IDX_W      = 2
) (
  input  logic [IDX_W-1:0]             sel_idx,
  input  logic [NUM_SLAVES-1:0]        PREADY,
  input  logic [NUM_SLAVES-1:0]        PSLVERR,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
  output logic                         sel_ready,
  output logic                         sel_slverr,
  output logic [DATA_W-1:0]            sel_rdata
);

  // Compare against every legal index so non-power-of-two slave counts
  // never index past the end of the buses.
  always_comb begin
    // NOTE: every output gets a default before the loop; a path that leaves
    // one unassigned would infer a latch.
    sel_ready  = 1'b0;
    sel_slverr = 1'b0;
    sel_rdata  = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (sel_idx == IDX_W'(k)) begin
        sel_ready  = PREADY[k];
        sel_slverr = PSLVERR[k];
        sel_rdata  = PRDATA[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB4 master: local request/response port in front of an IDLE/SETUP/ACCESS
// state machine driving up to NUM_SLAVES peripherals, with address decode,
// wait states, byte strobes, slave error reporting and an access timeout.
module apb_master_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SLV_ADDR_W = 12,
  parameter int TIMEOUT    = 16
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  input  logic [DATA_W/8-1:0]          req_strb,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic [apb_pkg::STATUS_W-1:0] rsp_status,
  output logic [NUM_SLAVES-1:0]        PSEL,
  output logic                         PENABLE,
  output logic                         PWRITE,
  output logic [ADDR_W-1:0]            PADDR,
  output logic [DATA_W-1:0]            PWDATA,
  output logic [DATA_W/8-1:0]          PSTRB,
  input  logic [NUM_SLAVES-1:0]        PREADY,
  input  logic [NUM_SLAVES-1:0]        PSLVERR,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA
);

  import apb_pkg::*;

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

  apb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    sel_idx_q, sel_idx_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  apb_status_t         rsp_status_q, rsp_status_d;

  logic [ADDR_W-1:0]   req_idx_full;
  logic                req_in_range;
  logic [IDX_W-1:0]    req_idx;

  logic                sel_ready;
  logic                sel_slverr;
  logic [DATA_W-1:0]   sel_rdata;

  // Full-width compare so high addresses never alias onto a real slave.
  assign req_idx_full = req_addr >> SLV_ADDR_W;
  assign req_in_range = req_idx_full < ADDR_W'(NUM_SLAVES);
  assign req_idx      = req_idx_full[IDX_W-1:0];

  assign req_ready = (state_q == IDLE) && !PRESET;

  apb_slave_mux #(
    .NUM_SLAVES (NUM_SLAVES),
    .DATA_W     (DATA_W),
    .IDX_W      (IDX_W)
  ) u_slave_mux (
    .sel_idx    (sel_idx_q),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR),
    .PRDATA     (PRDATA),
    .sel_ready  (sel_ready),
    .sel_slverr (sel_slverr),
    .sel_rdata  (sel_rdata)
  );

  // Next-state and next-output logic; APB fields hold unless a new
  // transfer is accepted, the response is a single-cycle pulse.
  always_comb begin
    state_d      = state_q;
    sel_idx_d    = sel_idx_q;
    wait_cnt_d   = wait_cnt_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = '0;
    rsp_status_d = OKAY;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_in_range) begin
            state_d    = SETUP;
            sel_idx_d  = req_idx;
            wait_cnt_d = '0;
            psel_d     = NUM_SLAVES'(1) << req_idx;
            penable_d  = 1'b0;
            pwrite_d   = req_write;
            paddr_d    = req_addr;
            pwdata_d   = req_wdata;
            pstrb_d    = req_write ? req_strb : '0;
          end else begin
            rsp_valid_d  = 1'b1;
            rsp_status_d = DECERR;
          end
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end

      ACCESS: begin
        if (sel_ready) begin
          state_d      = IDLE;
          psel_d       = '0;
          penable_d    = 1'b0;
          wait_cnt_d   = '0;
          rsp_valid_d  = 1'b1;
          rsp_status_d = sel_slverr ? SLVERR : OKAY;
          rsp_rdata_d  = (!pwrite_q && !sel_slverr) ? sel_rdata : '0;
        end else if ((TIMEOUT != 0) && (wait_cnt_q == WAIT_LAST)) begin
          state_d      = IDLE;
          psel_d       = '0;
          penable_d    = 1'b0;
          wait_cnt_d   = '0;
          rsp_valid_d  = 1'b1;
          rsp_status_d = apb_pkg::TIMEOUT;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything and drops any
  // transfer in flight without a response.
  always_ff @(posedge PCLK) begin
    // NOTE: non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    if (PRESET) begin
      state_q      <= IDLE;
      sel_idx_q    <= '0;
      wait_cnt_q   <= '0;
      psel_q       <= '0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= OKAY;
    end else begin
      state_q      <= state_d;
      sel_idx_q    <= sel_idx_d;
      wait_cnt_q   <= wait_cnt_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  assign PSEL       = psel_q;
  assign PENABLE    = penable_q;
  assign PWRITE     = pwrite_q;
  assign PADDR      = paddr_q;
  assign PWDATA     = pwdata_q;
  assign PSTRB      = pstrb_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_status = rsp_status_q;

endmodule
